// File: rtl/yrv_uart_tx.sv
// 8N1 UART transmitter with one-byte holding register behind the shift register.
// Frames are sent LSB first; a held byte follows the previous stop bit with no idle gap.
module yrv_uart_tx #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ser_txd,
    output logic       tx_busy,
    output logic       frame_done
);

    localparam int unsigned CPB = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(CPB - 2);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic            r_stop;
    logic [7:0]      r_shift;
    logic [7:0]      r_hold;
    logic            r_hold_full;
    logic            r_loaded;
    logic            r_txd;
    logic            r_done;

    logic w_tick;
    logic w_last_stop;
    logic w_frame_end;
    logic w_take;
    logic w_xfer;

    assign w_tick      = (r_baud == BAUD_LAST);
    assign w_last_stop = (r_state == S_STOP) && (r_stop == STOP_LAST);
    assign w_frame_end = w_last_stop && w_tick;
    assign w_take      = ((r_state == S_IDLE) && r_hold_full && !r_loaded)
                       || (w_frame_end && r_hold_full);
    assign w_xfer      = tx_valid && !r_hold_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_xfer) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
        end else if (w_take) begin
            r_hold_full <= 1'b0;
        end
    end

    // From IDLE the shifter loads one cycle before START, so the start bit
    // begins two edges after the handshake; r_loaded marks that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_stop   <= 1'b0;
            r_shift  <= '0;
            r_loaded <= 1'b0;
            r_txd    <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last_stop && (r_baud == BAUD_PRE);
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (r_loaded) begin
                        r_loaded <= 1'b0;
                        r_state  <= S_START;
                        r_txd    <= 1'b0;
                    end else if (r_hold_full) begin
                        r_shift  <= r_hold;
                        r_loaded <= 1'b1;
                    end
                end
                S_START: begin
                    r_baud <= w_tick ? '0 : r_baud + 1'b1;
                    if (w_tick) begin
                        r_state <= S_DATA;
                        r_bit   <= '0;
                        r_txd   <= r_shift[0];
                    end
                end
                S_DATA: begin
                    r_baud <= w_tick ? '0 : r_baud + 1'b1;
                    if (w_tick) begin
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_stop  <= 1'b0;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_txd   <= r_shift[1];
                        end
                    end
                end
                S_STOP: begin
                    r_baud <= w_tick ? '0 : r_baud + 1'b1;
                    if (w_tick) begin
                        if (r_stop == STOP_LAST) begin
                            if (r_hold_full) begin
                                r_shift <= r_hold;
                                r_state <= S_START;
                                r_txd   <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_stop <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready   = !r_hold_full;
    assign tx_busy    = (r_state != S_IDLE) || r_hold_full || r_loaded;
    assign ser_txd    = r_txd;
    assign frame_done = r_done;

endmodule

// File: tb/tb_yrv_uart_tx.sv
// Directed bench for yrv_uart_tx with CPB=8: one-stop-bit instance A, two-stop-bit instance B.
// Line state is logged every falling clock edge and decoded mid-bit afterwards.
module tb_yrv_uart_tx;

    localparam int NLOG = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a_data = '0;
    logic       a_valid = 1'b0;
    logic       a_ready, a_txd, a_busy, a_done;
    logic [7:0] b_data = '0;
    logic       b_valid = 1'b0;
    logic       b_ready, b_txd, b_busy, b_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic txd_a [0:NLOG-1];
    logic done_a[0:NLOG-1];
    logic rdy_a [0:NLOG-1];
    logic busy_a[0:NLOG-1];
    logic txd_b [0:NLOG-1];
    logic done_b[0:NLOG-1];

    yrv_uart_tx #(.CLK_HZ(8), .BAUD(1), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .reset(reset), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .ser_txd(a_txd), .tx_busy(a_busy), .frame_done(a_done)
    );

    yrv_uart_tx #(.CLK_HZ(8), .BAUD(1), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .reset(reset), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .ser_txd(b_txd), .tx_busy(b_busy), .frame_done(b_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cyc < NLOG) begin
            txd_a[cyc]  <= a_txd;
            done_a[cyc] <= a_done;
            rdy_a[cyc]  <= a_ready;
            busy_a[cyc] <= a_busy;
            txd_b[cyc]  <= b_txd;
            done_b[cyc] <= b_done;
        end
        cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // which: 0 txd_a, 1 done_a, 2 rdy_a, 3 busy_a, 4 txd_b, 5 done_b
    function automatic logic get(input int which, input int i);
        if (i < 0 || i >= NLOG) return 1'bx;
        case (which)
            0: return txd_a[i];
            1: return done_a[i];
            2: return rdy_a[i];
            3: return busy_a[i];
            4: return txd_b[i];
            default: return done_b[i];
        endcase
    endfunction

    function automatic int cnt(input int which, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i < hi; i++) if (get(which, i) === 1'b1) n++;
        return n;
    endfunction

    function automatic int find_start(input int which, input int lo, input int hi);
        for (int i = (lo < 1 ? 1 : lo); i < hi; i++)
            if (get(which, i) === 1'b0 && get(which, i - 1) === 1'b1) return i;
        return -1;
    endfunction

    // Mid-bit receiver: start mid s+4, data bit k mid s+12+8k.
    function automatic logic [7:0] dec(input int which, input int s);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = get(which, s + 12 + 8 * k);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Leaves tx_valid high; acc = log index of the falling edge after the transfer edge.
    task automatic push_a(input logic [7:0] b, output int acc);
        logic r;
        logic ok;
        ok = 1'b0;
        a_valid = 1'b1;
        a_data = b;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            r = a_ready;
            @(posedge clk);
            #1;
            if (r) ok = 1'b1;
        end
        acc = cyc;
        chk("accept_in_time", {31'd0, ok}, 32'd1);
    endtask

    int acc1, acc2, acc3, s1, s2, s3, s, guard;
    logic [9:0] pat55;

    initial begin
        pat55 = 10'h2AA;
        wait_cyc(3);
        reset = 1'b0;

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle_txd", {31'd0, a_txd}, 32'd1);
            chk("idle_ready", {31'd0, a_ready}, 32'd1);
            chk("idle_busy", {31'd0, a_busy}, 32'd0);
            chk("idle_done", {31'd0, a_done}, 32'd0);
        end
        step();

        // 0x55
        push_a(8'h55, acc1);
        a_valid = 1'b0;
        wait_cyc(100);
        s1 = find_start(0, acc1, acc1 + 20);
        chk("t55_start_latency", s1, acc1 + 2);
        if (s1 < 0) s1 = acc1 + 2;
        for (int k = 0; k < 10; k++)
            chk("t55_line_bit", {31'd0, get(0, s1 + 4 + 8 * k)}, {31'd0, pat55[k]});
        chk("t55_byte", dec(0, s1), 32'h55);
        chk("t55_stop_high", cnt(0, s1 + 72, s1 + 80), 8);
        chk("t55_done_pos", {31'd0, get(1, s1 + 79)}, 32'd1);
        chk("t55_done_once", cnt(1, acc1, acc1 + 100), 1);
        chk("t55_busy_mid", {31'd0, get(3, s1 + 40)}, 32'd1);
        chk("t55_busy_after", {31'd0, get(3, s1 + 85)}, 32'd0);
        chk("t55_ready_after", {31'd0, get(2, s1 + 85)}, 32'd1);

        // 0xA3 then 0x0F, tx_valid held
        push_a(8'hA3, acc1);
        push_a(8'h0F, acc2);
        a_valid = 1'b0;
        wait_cyc(200);
        s1 = find_start(0, acc1, acc1 + 20);
        chk("b2b_start_latency", s1, acc1 + 2);
        if (s1 < 0) s1 = acc1 + 2;
        chk("b2b_second_accept", acc2, acc1 + 2);
        s2 = find_start(0, s1 + 77, s1 + 120);
        chk("b2b_contiguous", s2, s1 + 80);
        if (s2 < 0) s2 = s1 + 80;
        chk("b2b_byte1", dec(0, s1), 32'hA3);
        chk("b2b_byte2", dec(0, s2), 32'h0F);
        chk("b2b_done_count", cnt(1, acc1, s2 + 100), 2);

        // back-pressure: three bytes
        push_a(8'h11, acc1);
        push_a(8'h22, acc2);
        push_a(8'h33, acc3);
        a_valid = 1'b0;
        wait_cyc(300);
        s1 = find_start(0, acc1, acc1 + 20);
        chk("bp_start_latency", s1, acc1 + 2);
        if (s1 < 0) s1 = acc1 + 2;
        chk("bp_ready_low_mid", {31'd0, get(2, s1 + 60)}, 32'd0);
        chk("bp_ready_low_end", {31'd0, get(2, s1 + 79)}, 32'd0);
        chk("bp_ready_release", {31'd0, get(2, s1 + 80)}, 32'd1);
        chk("bp_third_accept", acc3, s1 + 81);
        s2 = find_start(0, s1 + 77, s1 + 120);
        chk("bp_frame2_start", s2, s1 + 80);
        if (s2 < 0) s2 = s1 + 80;
        s3 = find_start(0, s2 + 77, s2 + 120);
        chk("bp_frame3_start", s3, s2 + 80);
        if (s3 < 0) s3 = s2 + 80;
        chk("bp_byte1", dec(0, s1), 32'h11);
        chk("bp_byte2", dec(0, s2), 32'h22);
        chk("bp_byte3", dec(0, s3), 32'h33);
        chk("bp_no_extra_frame", find_start(0, s3 + 77, s3 + 140), 32'hFFFF_FFFF);
        chk("bp_idle_after", cnt(0, s3 + 80, s3 + 100), 20);
        chk("bp_done_count", cnt(1, acc1, s3 + 100), 3);

        // reset at clk 30 of a 0x00 frame with 0x5A pending
        push_a(8'h00, acc1);
        push_a(8'h5A, acc2);
        a_valid = 1'b0;
        s = acc1 + 2;
        guard = 0;
        while (cyc <= s + 29 && guard < 200) begin
            step();
            guard++;
        end
        chk("rst_reach_clk30", {31'd0, (guard < 200)}, 32'd1);
        chk("rst_line_low_before", {31'd0, get(0, s + 29)}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_txd", {31'd0, a_txd}, 32'd1);
        chk("rst_ready", {31'd0, a_ready}, 32'd1);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        step();
        reset = 1'b0;
        acc1 = cyc;
        wait_cyc(20);
        chk("rst_pending_dropped", cnt(0, acc1, acc1 + 20), 20);
        push_a(8'hFF, acc1);
        a_valid = 1'b0;
        wait_cyc(100);
        s1 = find_start(0, acc1, acc1 + 20);
        chk("rst_ff_start", s1, acc1 + 2);
        if (s1 < 0) s1 = acc1 + 2;
        chk("rst_ff_start_low", cnt(0, s1, s1 + 8), 0);
        chk("rst_ff_byte", dec(0, s1), 32'hFF);
        chk("rst_ff_done", cnt(1, acc1, acc1 + 100), 1);

        // two stop bits, 0x81
        chk("sb2_ready_idle", {31'd0, b_ready}, 32'd1);
        b_valid = 1'b1;
        b_data = 8'h81;
        step();
        acc1 = cyc;
        b_valid = 1'b0;
        wait_cyc(120);
        s1 = find_start(4, acc1, acc1 + 20);
        chk("sb2_start_latency", s1, acc1 + 2);
        if (s1 < 0) s1 = acc1 + 2;
        chk("sb2_byte", dec(4, s1), 32'h81);
        chk("sb2_stop_16", cnt(4, s1 + 72, s1 + 88), 16);
        chk("sb2_idle_after", {31'd0, get(4, s1 + 88)}, 32'd1);
        chk("sb2_done_clk88", {31'd0, get(5, s1 + 87)}, 32'd1);
        chk("sb2_no_done_clk80", {31'd0, get(5, s1 + 79)}, 32'd0);
        chk("sb2_done_once", cnt(5, acc1, acc1 + 120), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
